uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding a UART TX FIFO; optional burst mode via UART_TX_ARB_BURST_EN
module uart_tx_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         fifo_full,
    output logic                         fifo_write_en,
    output logic [DATA_BITS-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         busy
);

    localparam int OW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and BURST_LEN 1..16");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

    state_t          state;
    logic            found;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   idx;
    logic            write_ok;

`ifdef UART_TX_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0]   burst_cnt;
`endif

    // Search starts just past the last owner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = owner;
        idx    = owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = OW'((int'(owner) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Reset masks the strobe so an in-flight byte is dropped, not written.
    assign write_ok      = (state == WRITE) && !fifo_full && !reset;
    assign fifo_write_en = write_ok;
    assign busy          = (state != IDLE);

    always_comb begin
        gnt = '0;
        if (write_ok) begin
            gnt[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= OW'(NUM_REQ - 1);
            fifo_data_in <= '0;
`ifdef UART_TX_ARB_BURST_EN
            burst_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= winner;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    fifo_data_in <= req_data[int'(owner)*DATA_BITS +: DATA_BITS];
                    state        <= WRITE;
                end
                WRITE: begin
                    if (!fifo_full) begin
`ifdef UART_TX_ARB_BURST_EN
                        if (req[owner] && (int'(burst_cnt) < BURST_LEN - 1)) begin
                            burst_cnt <= burst_cnt + BW'(1);
                            state     <= LOAD;
                        end else begin
                            burst_cnt <= '0;
                            state     <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
